mem_access_unit: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle memory stage of the five-stage CPU. It sits between EX/MEM and MEM/WB and issues byte/half/word/double loads and stores over a request/acknowledge bus, so memory latency is variable. Lanes and sign/zero extension scale with the data width. The pipeline is stalled while an access is outstanding.

---
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage between EX/MEM and MEM/WB, talking to memory over a req/ack bus.
// Optional misalignment exceptions are enabled by defining MEM_ALIGN_EXC_EN.
module mem_access_unit #(
    parameter  int DW    = 32,
    parameter  int AW    = 32,
    localparam int LANES = DW / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic             ld_i,
    input  logic             st_i,
    input  logic [1:0]       size_i,
    input  logic             sign_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DW-1:0]    sdata_i,
    output logic             stall_o,
    output logic             wb_valid_o,
    output logic [4:0]       wd_o,
    output logic             wreg_o,
    output logic [DW-1:0]    wdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [LANES-1:0] mem_sel_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic [DW-1:0]    mem_rdata_i,
    input  logic             mem_ack_i,
    output logic             exc_o,
    output logic [AW-1:0]    badvaddr_o
);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             r_state;
    logic               r_wb_valid, r_wreg, r_req, r_we, r_is_ld, r_sign;
    logic [4:0]         r_wd;
    logic [DW-1:0]      r_wdata, r_bus_wdata;
    logic [AW-1:0]      r_addr;
    logic [LANES-1:0]   r_sel;
    logic [1:0]         r_size;
    logic [LW-1:0]      r_off;

    logic               w_accept;
    int                 w_nbytes, w_lbits;
    logic [LW-1:0]      w_idx, w_mask, w_off;
    logic [LANES-1:0]   w_sel;
    logic [DW-1:0]      w_st_data, w_rshift, w_load;
    logic               w_fill;

    assign w_accept = valid_i && (r_state != REQ);
    assign stall_o  = (r_state == REQ) || (w_accept && (ld_i || st_i));

    // Access size in bytes, clipped to the bus width so an illegal double on a 32-bit bus stays in range.
    assign w_nbytes = ((1 << size_i) > LANES) ? LANES : (1 << size_i);
    assign w_idx    = addr_i[LW-1:0];
    assign w_mask   = LW'(w_nbytes - 1);
    assign w_off    = w_idx & ~w_mask;
    assign w_sel    = LANES'(((1 << w_nbytes) - 1) << w_off);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_st_lane
            assign w_st_data[8*gi +: 8] = sdata_i[8*(gi % w_nbytes) +: 8];
        end
    endgenerate

    assign w_rshift = mem_rdata_i >> {r_off, 3'b000};
    assign w_lbits  = ((8 << r_size) > DW) ? DW : (8 << r_size);
    assign w_fill   = r_sign & w_rshift[w_lbits-1];

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_ld_bit
            assign w_load[gi] = (gi < w_lbits) ? w_rshift[gi] : w_fill;
        end
    endgenerate

`ifdef MEM_ALIGN_EXC_EN
    logic          r_exc;
    logic [AW-1:0] r_badvaddr;
    logic          w_misalign;
    assign w_misalign = (w_idx & w_mask) != '0;
    assign exc_o      = r_exc;
    assign badvaddr_o = r_badvaddr;
`else
    assign exc_o      = 1'b0;
    assign badvaddr_o = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wb_valid  <= 1'b0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_wdata     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_bus_wdata <= '0;
            r_is_ld     <= 1'b0;
            r_size      <= '0;
            r_sign      <= 1'b0;
            r_off       <= '0;
`ifdef MEM_ALIGN_EXC_EN
            r_exc       <= 1'b0;
            r_badvaddr  <= '0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
            r_exc      <= 1'b0;
`endif
            case (r_state)
                REQ: begin
                    if (mem_ack_i) begin
                        r_req      <= 1'b0;
                        r_state    <= RESP;
                        r_wb_valid <= 1'b1;
                        if (r_is_ld)
                            r_wdata <= w_load;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_wd <= wd_i;
                        if (!ld_i && !st_i) begin
                            r_wreg     <= wreg_i;
                            r_wdata    <= wdata_i;
                            r_state    <= RESP;
                            r_wb_valid <= 1'b1;
                        end
`ifdef MEM_ALIGN_EXC_EN
                        else if (w_misalign) begin
                            r_wreg     <= 1'b0;
                            r_wdata    <= '0;
                            r_state    <= RESP;
                            r_wb_valid <= 1'b1;
                            r_exc      <= 1'b1;
                            r_badvaddr <= addr_i;
                        end
`endif
                        else begin
                            r_wreg      <= ld_i & wreg_i;
                            r_wdata     <= '0;
                            r_state     <= REQ;
                            r_req       <= 1'b1;
                            r_we        <= st_i;
                            r_addr      <= {addr_i[AW-1:LW], {LW{1'b0}}};
                            r_sel       <= w_sel;
                            r_bus_wdata <= w_st_data;
                            r_is_ld     <= ld_i;
                            r_size      <= size_i;
                            r_sign      <= sign_i;
                            r_off       <= w_off;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign wb_valid_o  = r_wb_valid;
    assign wd_o        = r_wd;
    assign wreg_o      = r_wreg;
    assign wdata_o     = r_wdata;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_sel_o   = r_sel;
    assign mem_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance for most cases and a 64-bit one for lane scaling.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance signals
    logic        a_valid, a_wreg, a_ld, a_st, a_sign, a_ack;
    logic [4:0]  a_wd;
    logic [1:0]  a_size;
    logic [31:0] a_wdata_i, a_addr, a_sdata, a_rdata;
    logic        a_stall, a_wb, a_wreg_o, a_req, a_we, a_exc;
    logic [4:0]  a_wd_o;
    logic [31:0] a_wdata, a_maddr, a_mwdata, a_bad;
    logic [3:0]  a_sel;

    // 64-bit instance signals
    logic        b_valid, b_wreg, b_ld, b_st, b_sign, b_ack;
    logic [4:0]  b_wd;
    logic [1:0]  b_size;
    logic [63:0] b_wdata_i, b_sdata, b_rdata;
    logic [31:0] b_addr;
    logic        b_stall, b_wb, b_wreg_o, b_req, b_we, b_exc;
    logic [4:0]  b_wd_o;
    logic [63:0] b_wdata, b_mwdata;
    logic [31:0] b_maddr, b_bad;
    logic [7:0]  b_sel;

    mem_access_unit #(.DW(32), .AW(32)) dut32 (
        .clk(clk), .rst(rst), .valid_i(a_valid), .wd_i(a_wd), .wreg_i(a_wreg),
        .wdata_i(a_wdata_i), .ld_i(a_ld), .st_i(a_st), .size_i(a_size), .sign_i(a_sign),
        .addr_i(a_addr), .sdata_i(a_sdata), .stall_o(a_stall), .wb_valid_o(a_wb),
        .wd_o(a_wd_o), .wreg_o(a_wreg_o), .wdata_o(a_wdata), .mem_req_o(a_req),
        .mem_we_o(a_we), .mem_addr_o(a_maddr), .mem_sel_o(a_sel), .mem_wdata_o(a_mwdata),
        .mem_rdata_i(a_rdata), .mem_ack_i(a_ack), .exc_o(a_exc), .badvaddr_o(a_bad)
    );

    mem_access_unit #(.DW(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst), .valid_i(b_valid), .wd_i(b_wd), .wreg_i(b_wreg),
        .wdata_i(b_wdata_i), .ld_i(b_ld), .st_i(b_st), .size_i(b_size), .sign_i(b_sign),
        .addr_i(b_addr), .sdata_i(b_sdata), .stall_o(b_stall), .wb_valid_o(b_wb),
        .wd_o(b_wd_o), .wreg_o(b_wreg_o), .wdata_o(b_wdata), .mem_req_o(b_req),
        .mem_we_o(b_we), .mem_addr_o(b_maddr), .mem_sel_o(b_sel), .mem_wdata_o(b_mwdata),
        .mem_rdata_i(b_rdata), .mem_ack_i(b_ack), .exc_o(b_exc), .badvaddr_o(b_bad)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        a_valid = 0; a_ld = 0; a_st = 0; a_wreg = 0; a_wd = 0; a_size = 0;
        a_sign = 0; a_addr = 0; a_sdata = 0; a_wdata_i = 0; a_ack = 0; a_rdata = 0;
    endtask

    initial begin
        a_idle();
        b_valid = 0; b_ld = 0; b_st = 0; b_wreg = 0; b_wd = 0; b_size = 0;
        b_sign = 0; b_addr = 0; b_sdata = 0; b_wdata_i = 0; b_ack = 0; b_rdata = 0;
        rst = 1;
        step(); step();
        $display("reset");
        chk("rst_wb",    a_wb, 0);
        chk("rst_req",   a_req, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_sel",   a_sel, 0);
        chk("rst_exc",   a_exc, 0);
        chk("rst_b_req", b_req, 0);
        rst = 0;
        step();

        // Stray ack while idle must not produce a result.
        $display("stray ack in IDLE");
        a_ack = 1; a_rdata = 32'hFFFF_FFFF;
        step();
        a_ack = 0;
        chk("stray_wb",  a_wb, 0);
        chk("stray_req", a_req, 0);

        // LB signed at 0x103, ack three cycles after the request.
        $display("LB 0x103 sign");
        a_valid = 1; a_ld = 1; a_size = 0; a_sign = 1; a_addr = 32'h103; a_wd = 5; a_wreg = 1;
        #1;
        chk("lb_stall_n0", a_stall, 1);
        step();
        chk("lb_req",      a_req, 1);
        chk("lb_sel",      a_sel, 4'b1000);
        chk("lb_addr",     a_maddr, 32'h100);
        chk("lb_we",       a_we, 0);
        chk("lb_stall_n1", a_stall, 1);
        step();
        chk("lb_stall_n2", a_stall, 1);
        chk("lb_req_n2",   a_req, 1);
        step();
        chk("lb_stall_n3", a_stall, 1);
        step();
        a_ack = 1; a_rdata = 32'h80AA55CC; a_valid = 0;
        #1;
        chk("lb_stall_n4", a_stall, 1);
        step();
        a_ack = 0;
        chk("lb_wb",       a_wb, 1);
        chk("lb_wdata",    a_wdata, 32'hFFFF_FF80);
        chk("lb_wd",       a_wd_o, 5);
        chk("lb_wreg",     a_wreg_o, 1);
        chk("lb_req_done", a_req, 0);
        chk("lb_stall_n5", a_stall, 0);
        step();
        chk("lb_wb_pulse", a_wb, 0);

        // SH at 0x202: upper half-word lanes, data replicated.
        $display("SH 0x202");
        a_idle();
        a_valid = 1; a_st = 1; a_size = 1; a_addr = 32'h202; a_sdata = 32'h1234BEEF; a_wd = 7; a_wreg = 1;
        step();
        chk("sh_we",    a_we, 1);
        chk("sh_sel",   a_sel, 4'b1100);
        chk("sh_wdata", a_mwdata, 32'hBEEFBEEF);
        chk("sh_addr",  a_maddr, 32'h200);
        a_ack = 1; a_valid = 0;
        step();
        a_ack = 0;
        chk("sh_wb",    a_wb, 1);
        chk("sh_wreg",  a_wreg_o, 0);
        chk("sh_wdo",   a_wdata, 0);
        step();

        // 64-bit LW unsigned at offset 4.
        $display("LW64 0x100C");
        b_valid = 1; b_ld = 1; b_size = 2; b_sign = 0; b_addr = 32'h100C; b_wd = 3; b_wreg = 1;
        step();
        chk("lw64_sel",  b_sel, 8'hF0);
        chk("lw64_addr", b_maddr, 32'h1008);
        b_ack = 1; b_rdata = 64'hF000_0001_0000_0000; b_valid = 0;
        step();
        b_ack = 0;
        chk("lw64_wb",    b_wb, 1);
        chk("lw64_wdata", b_wdata, 64'h0000_0000_F000_0001);
        step();

        // Back-to-back ADD, LW (zero-wait ack), SW.
        $display("ADD/LW/SW back-to-back");
        a_idle();
        a_valid = 1; a_wd = 1; a_wreg = 1; a_wdata_i = 32'h11;
        step();
        chk("b2b_wb_c1",    a_wb, 1);
        chk("b2b_add_data", a_wdata, 32'h11);
        a_ld = 1; a_size = 2; a_addr = 32'h400; a_wd = 2;
        #1;
        chk("b2b_stall_c1", a_stall, 1);
        step();
        chk("b2b_wb_c2",  a_wb, 0);
        chk("b2b_req_c2", a_req, 1);
        a_ack = 1; a_rdata = 32'hDEADBEEF;
        step();
        chk("b2b_wb_c3",   a_wb, 1);
        chk("b2b_lw_data", a_wdata, 32'hDEADBEEF);
        chk("b2b_lw_wd",   a_wd_o, 2);
        a_ack = 0; a_ld = 0; a_st = 1; a_addr = 32'h404; a_sdata = 32'hCAFE0000; a_wd = 9;
        step();
        chk("b2b_wb_c4",  a_wb, 0);
        chk("b2b_req_c4", a_req, 1);
        chk("b2b_we_c4",  a_we, 1);
        chk("b2b_sw_dat", a_mwdata, 32'hCAFE0000);
        a_valid = 0; a_ack = 1;
        step();
        a_ack = 0;
        chk("b2b_wb_c5",   a_wb, 1);
        chk("b2b_sw_wreg", a_wreg_o, 0);
        step();

        // Reset while a request is outstanding; the late ack must be dropped.
        $display("reset during REQ");
        a_idle();
        a_valid = 1; a_ld = 1; a_size = 2; a_addr = 32'h500; a_wd = 4; a_wreg = 1;
        step();
        chk("rreq_req", a_req, 1);
        rst = 1;
        step();
        rst = 0; a_ack = 1; a_valid = 0; a_rdata = 32'h12345678;
        #1;
        chk("rreq_req_drop", a_req, 0);
        chk("rreq_sel",      a_sel, 0);
        chk("rreq_stall",    a_stall, 0);
        step();
        a_ack = 0;
        chk("rreq_wb",    a_wb, 0);
        chk("rreq_wdata", a_wdata, 0);
        chk("rreq_req2",  a_req, 0);
        step();

        // LH at odd address 0x301.
        $display("LH 0x301");
        a_idle();
        a_valid = 1; a_ld = 1; a_size = 1; a_sign = 1; a_addr = 32'h301; a_wd = 6; a_wreg = 1;
        step();
`ifdef MEM_ALIGN_EXC_EN
        a_valid = 0;
        chk("lh_exc_req",  a_req, 0);
        chk("lh_exc",      a_exc, 1);
        chk("lh_bad",      a_bad, 32'h301);
        chk("lh_exc_wb",   a_wb, 1);
        chk("lh_exc_wreg", a_wreg_o, 0);
        step();
        chk("lh_exc_pulse", a_exc, 0);
        chk("lh_bad_hold",  a_bad, 32'h301);
`else
        chk("lh_req",  a_req, 1);
        chk("lh_sel",  a_sel, 4'b0011);
        chk("lh_addr", a_maddr, 32'h300);
        chk("lh_exc",  a_exc, 0);
        a_valid = 0; a_ack = 1; a_rdata = 32'h5555ABCD;
        step();
        a_ack = 0;
        chk("lh_wb",    a_wb, 1);
        chk("lh_wdata", a_wdata, 32'hFFFFABCD);
        chk("lh_bad",   a_bad, 0);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
